// File: rtl/frame_receiver.sv
// frame_receiver: receive end of the fixed-length byte-frame link.
// A frame is PAYLOAD_BYTES payload bytes followed by one check byte. The
// check byte is the XOR of the payload bytes. Payload bytes are gathered in a
// shadow buffer and copied to frame_out only when the check byte matches.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   rx_valid    rx_data carries a byte this cycle
//   rx_data     incoming byte (ignored when rx_valid=0)
//   frame_out   last good payload, byte k in bits [8k+7:8k]
//   frame_valid one-cycle pulse: frame_out just took a good frame
//   crc_error   one-cycle pulse: check byte mismatch, frame discarded
//   timeout     one-cycle pulse: partial frame aborted after idle gap
//   busy        high while a frame is in progress
//   rx_crc      running XOR of payload bytes in the current frame
//   good_count  good frames received, saturating
//   err_count   crc_error plus timeout events, saturating
//
// Handshake: there is no back-pressure. A byte is transferred on every rising
// edge where rx_valid=1; the receiver always accepts it.
module frame_receiver #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic [8*PAYLOAD_BYTES-1:0] frame_out,
  output logic                       frame_valid,
  output logic                       crc_error,
  output logic                       timeout,
  output logic                       busy,
  output logic [7:0]                 rx_crc,
  output logic [7:0]                 good_count,
  output logic [7:0]                 err_count
);

  localparam int IXW = $clog2(PAYLOAD_BYTES + 1);
  localparam int IW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t                       state_q, state_d;
  logic [8*PAYLOAD_BYTES-1:0]   shadow_q, shadow_d;
  logic [8*PAYLOAD_BYTES-1:0]   frame_q, frame_d;
  logic [IXW-1:0]               idx_q, idx_d;
  logic [IW-1:0]                idle_q, idle_d;
  logic [7:0]                   crc_q, crc_d;
  logic [7:0]                   good_q, good_d;
  logic [7:0]                   err_q, err_d;
  logic                         fv_q, fv_d;
  logic                         ce_q, ce_d;
  logic                         to_q, to_d;
  logic                         expire;

  // The idle gap expires on the cycle the counter would reach TIMEOUT_CYCLES;
  // an arriving byte in that same cycle takes priority.
  assign expire = (state_q != IDLE) && !rx_valid &&
                  (idle_q == IW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_valid) state_d = (PAYLOAD_BYTES == 1) ? CHECK : PAYLOAD;
      PAYLOAD: if (rx_valid && idx_q == IXW'(PAYLOAD_BYTES - 1)) state_d = CHECK;
               else if (expire) state_d = IDLE;
      CHECK:   if (rx_valid || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next-state
  always_comb begin
    shadow_d = shadow_q;
    frame_d  = frame_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    crc_d    = crc_q;
    good_d   = good_q;
    err_d    = err_q;
    fv_d     = 1'b0;
    ce_d     = 1'b0;
    to_d     = 1'b0;
    if (rx_valid) begin
      idle_d = '0;
      case (state_q)
        IDLE: begin
          shadow_d[7:0] = rx_data;
          crc_d         = rx_data;
          idx_d         = IXW'(1);
        end
        PAYLOAD: begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (idx_q == IXW'(k)) shadow_d[8*k +: 8] = rx_data;
          end
          crc_d = crc_q ^ rx_data;
          idx_d = idx_q + IXW'(1);
        end
        CHECK: begin
          if (rx_data == crc_q) begin
            frame_d = shadow_q;
            fv_d    = 1'b1;
            good_d  = (good_q != 8'hFF) ? good_q + 8'd1 : good_q;
          end else begin
            ce_d  = 1'b1;
            err_d = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
          end
          crc_d = '0;
          idx_d = '0;
        end
        default: ;
      endcase
    end else if (state_q != IDLE) begin
      if (expire) begin
        to_d     = 1'b1;
        err_d    = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        crc_d    = '0;
        idx_d    = '0;
        idle_d   = '0;
        shadow_d = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      frame_q  <= '0;
      idx_q    <= '0;
      idle_q   <= '0;
      crc_q    <= '0;
      good_q   <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ce_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      idle_q   <= idle_d;
      crc_q    <= crc_d;
      good_q   <= good_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ce_q     <= ce_d;
      to_q     <= to_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign crc_error   = ce_q;
  assign timeout     = to_q;
  assign rx_crc      = crc_q;
  assign good_count  = good_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_frame_receiver.sv
module tb_frame_receiver;

  localparam int P  = 16;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic [8*P-1:0] frame_out;
  logic           frame_valid, crc_error, timeout, busy;
  logic [7:0]     rx_crc, good_count, err_count;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int fv_cyc_q[$];

  frame_receiver #(.PAYLOAD_BYTES(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_out(frame_out), .frame_valid(frame_valid), .crc_error(crc_error),
    .timeout(timeout), .busy(busy), .rx_crc(rx_crc),
    .good_count(good_count), .err_count(err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // A frame is "in progress" when bytes are queued; the queue plus a gap
  // counter is all that is needed to predict every output.
  logic [7:0]     m_bytes[$];
  int             m_gap;
  logic [8*P-1:0] m_frame;
  int             m_good, m_err;
  logic           m_fv, m_ce, m_to;

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bytes.delete();
      m_gap = 0; m_frame = '0; m_good = 0; m_err = 0;
      m_fv = 0; m_ce = 0; m_to = 0;
    end else begin
      m_fv = 0; m_ce = 0; m_to = 0;
      if (m_bytes.size() > 0) begin
        if (rx_valid) begin
          m_gap = 0;
          if (m_bytes.size() < P) m_bytes.push_back(rx_data);
          else begin
            if (rx_data == xor_of(m_bytes)) begin
              for (int k = 0; k < P; k++) m_frame[8*k +: 8] = m_bytes[k];
              m_fv = 1;
              if (m_good < 255) m_good++;
            end else begin
              m_ce = 1;
              if (m_err < 255) m_err++;
            end
            m_bytes.delete();
          end
        end else begin
          m_gap++;
          if (m_gap == TO) begin
            m_to = 1;
            if (m_err < 255) m_err++;
            m_bytes.delete();
            m_gap = 0;
          end
        end
      end else if (rx_valid) begin
        m_bytes.push_back(rx_data);
        m_gap = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    cyc++;
    if (frame_valid) fv_cyc_q.push_back(cyc);
    if (!reset) begin
      vectors++;
      if (frame_out !== m_frame || frame_valid !== m_fv || crc_error !== m_ce ||
          timeout !== m_to || busy !== (m_bytes.size() > 0) ||
          rx_crc !== xor_of(m_bytes) || good_count !== 8'(m_good) ||
          err_count !== 8'(m_err)) begin
        miscompares++;
        $display("FAIL model cycle %0d: got fv=%b ce=%b to=%b busy=%b crc=%h good=%0d err=%0d frame=%h ; need fv=%b ce=%b to=%b busy=%b crc=%h good=%0d err=%0d frame=%h",
                 cyc, frame_valid, crc_error, timeout, busy, rx_crc, good_count, err_count, frame_out,
                 m_fv, m_ce, m_to, m_bytes.size() > 0, xor_of(m_bytes), m_good, m_err, m_frame);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h need %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_count_frame(input logic [7:0] chk);
    for (int i = 1; i <= P; i++) send_byte(8'(i));
    send_byte(chk);
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [127:0] COUNT_FRAME = 128'h100F0E0D0C0B0A090807060504030201;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_frame_out", frame_out, '0);
    check("reset_flags", {busy, frame_valid, crc_error, timeout}, 4'b0000);
    check("reset_counts", {rx_crc, good_count, err_count}, 24'h0);
    reset = 1'b0;
    idle(2);

    // good frame 01..10, check 10
    send_count_frame(8'h10);
    check("good_fv_pulse", frame_valid, 1'b1);
    check("good_byte0", frame_out[7:0], 8'h01);
    check("good_byte15", frame_out[127:120], 8'h10);
    check("good_count1", good_count, 8'd1);
    check("good_busy_low", busy, 1'b0);
    idle(1);
    check("good_fv_one_cycle", frame_valid, 1'b0);

    // bad check byte
    send_count_frame(8'h11);
    check("bad_ce_pulse", crc_error, 1'b1);
    check("bad_no_fv", frame_valid, 1'b0);
    check("bad_frame_held", frame_out, COUNT_FRAME);
    check("bad_err_count", err_count, 8'd1);
    idle(1);
    check("bad_ce_one_cycle", crc_error, 1'b0);

    // timeout after 5 bytes
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    idle(TO);
    idle(1);
    check("to_pulse", timeout, 1'b1);
    check("to_busy_low", busy, 1'b0);
    check("to_err_count", err_count, 8'd2);
    check("to_frame_held", frame_out, COUNT_FRAME);
    idle(1);
    send_count_frame(8'h10);
    check("after_to_fv", frame_valid, 1'b1);
    check("after_to_good", good_count, 8'd2);

    // gapped stream, 63 idle cycles between bytes
    for (int i = 0; i < P; i++) begin
      send_byte(8'hA5);
      idle(TO - 1);
    end
    send_byte(8'h00);
    idle(1);
    check("gap_fv", frame_valid, 1'b1);
    check("gap_frame", frame_out, {16{8'hA5}});
    check("gap_err_unchanged", err_count, 8'd2);

    // back-to-back frames from a clean reset
    do_reset();
    fv_cyc_q.delete();
    for (int i = 0; i < P; i++) send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < P; i++) send_byte(8'hFF);
    send_byte(8'h00);
    idle(2);
    check("b2b_pulses", 32'(fv_cyc_q.size()), 32'd2);
    if (fv_cyc_q.size() == 2) check("b2b_spacing", 32'(fv_cyc_q[1] - fv_cyc_q[0]), 32'd17);
    else check("b2b_spacing", 32'd0, 32'd17);
    check("b2b_frame", frame_out, {16{8'hFF}});
    check("b2b_good", good_count, 8'd2);

    // reset mid-frame
    for (int i = 0; i < 8; i++) send_byte(8'h33);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_frame", frame_out, '0);
    check("mid_rst_flags", {busy, frame_valid, crc_error, timeout}, 4'b0000);
    check("mid_rst_counts", {rx_crc, good_count, err_count}, 24'h0);
    @(negedge clk);
    reset = 1'b0;
    send_count_frame(8'h10);
    check("post_rst_fv", frame_valid, 1'b1);
    check("post_rst_frame", frame_out, COUNT_FRAME);
    check("post_rst_good", good_count, 8'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
